// File: rtl/pf_insn_queue_pkg.sv
// Shared CPU definitions for the prefetch/decode boundary: default widths
// and the instruction-entry record carried through the instruction queue.
package pf_insn_queue_pkg;

  localparam int AW = 30;
  localparam int DW = 32;

  typedef struct packed {
    logic          illegal;
    logic [AW+1:0] pc;
    logic [DW-1:0] insn;
  } insn_entry_t;

endpackage

// File: rtl/pf_insn_queue_sync_fifo_ptrs.sv
// Read/write pointer and occupancy bookkeeping for a power-of-two synchronous
// FIFO. Flush returns everything to the empty state on the next edge.
module pf_insn_queue_sync_fifo_ptrs #(
  parameter int LGDEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  output logic [LGDEPTH-1:0] rd_ptr,
  output logic [LGDEPTH-1:0] wr_ptr,
  output logic [LGDEPTH:0]   fill,
  output logic               full,
  output logic               empty
);

  localparam logic [LGDEPTH:0] FULL_COUNT = (LGDEPTH+1)'(1 << LGDEPTH);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  assign full  = (fill == FULL_COUNT);
  assign empty = (fill == '0);

endmodule

// File: rtl/pf_insn_queue.sv
// Instruction queue between the single-word prefetch and the decoder. Holds
// {illegal, pc, insn}; stops accepting after a bus-error word until flushed.
module pf_insn_queue
  import pf_insn_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = AW,
  parameter int DATA_WIDTH    = DW,
  parameter int LGDEPTH       = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_flush,
  input  logic                     i_pf_valid,
  input  logic                     i_pf_illegal,
  input  logic [DATA_WIDTH-1:0]    i_pf_insn,
  input  logic [ADDRESS_WIDTH+1:0] i_pf_pc,
  output logic                     o_pf_ready,
  output logic                     o_valid,
  output logic                     o_illegal,
  output logic [DATA_WIDTH-1:0]    o_insn,
  output logic [ADDRESS_WIDTH+1:0] o_pc,
  input  logic                     i_ready,
  output logic [LGDEPTH:0]         o_fill
);

  localparam int DEPTH = 1 << LGDEPTH;

  typedef struct packed {
    logic                     illegal;
    logic [ADDRESS_WIDTH+1:0] pc;
    logic [DATA_WIDTH-1:0]    insn;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [LGDEPTH-1:0] rd_ptr;
  logic [LGDEPTH-1:0] wr_ptr;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               err_seen;

  // Ready depends only on registered state and flush, never on i_ready.
  assign o_pf_ready = !full && !err_seen && !i_flush;
  assign o_valid    = !empty;
  assign push       = i_pf_valid && o_pf_ready;
  assign pop        = o_valid && i_ready && !i_flush;

  pf_insn_queue_sync_fifo_ptrs #(
    .LGDEPTH (LGDEPTH)
  ) u_ptrs (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .flush     (i_flush),
    .push      (push),
    .pop       (pop),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .fill      (o_fill),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= '{illegal: i_pf_illegal, pc: i_pf_pc, insn: i_pf_insn};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      err_seen <= 1'b0;
    else if (i_flush)
      err_seen <= 1'b0;
    else if (push && i_pf_illegal)
      err_seen <= 1'b1;
  end

  // Storage is not reset, so the illegal flag is qualified by valid.
  assign head      = mem[rd_ptr];
  assign o_illegal = o_valid && head.illegal;
  assign o_insn    = head.insn;
  assign o_pc      = head.pc;

endmodule

// File: doc/pf_insn_queue.md
Name: pf_insn_queue

Overview:
- Small instruction FIFO directly downstream of the single-word prefetch stage, upstream of the instruction decoder.
- Decouples decoder stalls from bus fetches so prefetch can keep fetching while decode holds.
- Carries instruction word, PC and bus-error (illegal) flag together.
- Flushes on branch or cache clear.

Parameters:
- ADDRESS_WIDTH, 30, word-address width; PCs are ADDRESS_WIDTH+2 bits (byte addresses).
- DATA_WIDTH, 32, instruction word width.
- LGDEPTH, 2, log2 of queue depth; DEPTH = 2**LGDEPTH. Legal range 1..4.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_flush  in  1  CPU new-PC or clear-cache; empties the queue.
- i_pf_valid  in  1  prefetch word valid.
- i_pf_illegal  in  1  prefetch word came from a bus error.
- i_pf_insn  in  DATA_WIDTH  prefetch instruction word.
- i_pf_pc  in  ADDRESS_WIDTH+2  PC of the prefetch word.
- o_pf_ready  out  1  queue accepts a word this cycle; drives prefetch i_ready.
- o_valid  out  1  head entry valid.
- o_illegal  out  1  head entry is a bus-error entry.
- o_insn  out  DATA_WIDTH  head instruction.
- o_pc  out  ADDRESS_WIDTH+2  head PC.
- i_ready  in  1  decoder accepts the head.
- o_fill  out  LGDEPTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): fill=0, rd/wr pointers=0, err_seen=0.
  - Resulting outputs: o_valid=0, o_illegal=0, o_pf_ready=1.
  - o_insn/o_pc are don't-care while o_valid=0.
- Storage: DEPTH entries of {illegal, pc, insn}; pointers are LGDEPTH bits and wrap modulo DEPTH.
- push = i_pf_valid && o_pf_ready && !i_flush.
- pop = o_valid && i_ready && !i_flush.
- o_pf_ready = (fill != DEPTH) && !err_seen && !i_flush. Combinational from registers and i_flush only; no path from i_ready.
- o_valid = (fill != 0).
- o_insn, o_pc and o_illegal are read combinationally from mem[rd_ptr].
- Latency: a word pushed in cycle N appears at the head in cycle N+1 if the queue was empty. No same-cycle bypass.
- Fill update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Full: no push, since o_pf_ready=0. Pop when full frees a slot the next cycle.
- Error latch: pushing an entry with i_pf_illegal=1 sets err_seen. While err_seen=1, o_pf_ready=0, so nothing is accepted after a bus-error word.
  - Entries ahead of the error word still drain normally.
  - The error entry itself stays at the head with o_valid=1 and o_illegal=1. Popping it is permitted.
- Flush (synchronous, highest priority after reset): next cycle fill=0, pointers=0, err_seen=0. Any push or pop in the flush cycle is discarded.
- Reset asserted mid-operation clears state immediately, regardless of clock.
- Prefetch contract: i_pf_insn, i_pf_pc and i_pf_illegal are stable while i_pf_valid=1 and o_pf_ready=0. The queue does not check this.

Decomposition:
- Shared CPU package: the instruction-entry record {illegal, pc, insn} typedef, plus default widths AW/DW.
- Sub-module sync_fifo_ptrs (pointer, fill and full/empty bookkeeping) is natural. The storage array and error latch stay in the top.

Test Plan:
- Reset, then push 0x11111111@pc 0x100, 0x22222222@0x104 with i_ready=0 -> fill=2, head 0x11111111/0x100.
  - Then i_ready=1 -> heads pop in order; o_valid=0 after two pops.
- Push 4 words with i_ready=0, LGDEPTH=2 -> fill=4, o_pf_ready=0; a fifth word is held until one pop, then accepted. Order preserved across pointer wrap.
- Queue at fill=2, push and pop in the same cycle -> fill stays 2; the head advances to the next PC.
- Push a word with i_pf_illegal=1 at pc 0x200 -> o_pf_ready=0 forever after.
  - Head reaches 0x200 with o_illegal=1.
  - i_flush -> err_seen cleared, o_pf_ready=1.
- Fill=3, then i_flush together with i_pf_valid and i_ready -> next cycle fill=0, o_valid=0, nothing from that cycle retained.
- Assert i_reset_n=0 between clock edges while fill=2 -> o_valid=0 and o_fill=0 before the next edge.
